// File: rtl/innerproduct_stream.sv
// Streaming inner-product engine: h = theta[0] + sum_k x[k]*theta[k].
// Features arrive LANES per beat; a two-stage MAC (lane products, then
// accumulate) reduces the vector and h is offered on a valid/ready port.
module innerproduct_stream #(
  parameter int unsigned       W         = 32,
  parameter int unsigned       N_FEAT    = 41,
  parameter int unsigned       LANES     = 4,
  parameter logic [N_FEAT-1:0] ZERO_MASK = 'h2,
  parameter bit                SAT       = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      theta_we,
  input  logic [$clog2(N_FEAT)-1:0] theta_addr,
  input  logic [W-1:0]              theta_wdata,
  output logic                      theta_err,
  input  logic                      x_valid,
  output logic                      x_ready,
  input  logic [LANES*W-1:0]        x_data,
  output logic                      h_valid,
  input  logic                      h_ready,
  output logic [W-1:0]              h_data,
  output logic                      busy
);

  localparam int unsigned BEATS = (N_FEAT + LANES - 1) / LANES;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned AW    = $clog2(N_FEAT);
  localparam int unsigned PW    = 2 * W;
  localparam int unsigned AccW  = 2 * W + $clog2(N_FEAT);

  localparam logic [CW-1:0] LastBeat = CW'(BEATS - 1);
  localparam logic signed [AccW-1:0] MaxV = {{(AccW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AccW-1:0] MinV = {{(AccW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StRun, StFlush1, StFlush2, StDone} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          beat_q, beat_d;
  logic                   x_ready_q, x_ready_d;
  logic                   h_valid_q, h_valid_d;
  logic                   busy_q, busy_d;
  logic [W-1:0]           h_data_q, h_data_d;
  logic                   theta_err_q, theta_err_d;
  logic [W-1:0]           theta_q [N_FEAT];
  logic [W-1:0]           theta_d [N_FEAT];
  logic signed [PW-1:0]   prod_q [LANES];
  logic signed [PW-1:0]   prod_d [LANES];
  logic                   pv_q, pv_d;
  logic signed [AccW-1:0] acc_q, acc_d;
  logic signed [AccW-1:0] lane_sum;
  logic [W-1:0]           result;
  logic                   x_fire, h_fire, theta_ok;

  assign x_fire    = x_valid & x_ready_q;
  assign h_fire    = h_valid_q & h_ready;
  assign x_ready   = x_ready_q;
  assign h_valid   = h_valid_q;
  assign h_data    = h_data_q;
  assign busy      = busy_q;
  assign theta_err = theta_err_q;

  // Theta register file: writes land only while idle and in range.
  always_comb begin
    theta_d     = theta_q;
    theta_ok    = theta_we && (state_q == StIdle) && (32'(theta_addr) < N_FEAT);
    theta_err_d = theta_we && !theta_ok;
    if (theta_ok) theta_d[theta_addr] = theta_wdata;
  end

  // Stage 1: per-lane terms (bias, masked, padding or signed full product).
  always_comb begin
    int unsigned idx;
    logic [W-1:0] xl;
    logic [W-1:0] th;
    prod_d = prod_q;
    pv_d   = x_fire;
    for (int unsigned j = 0; j < LANES; j++) begin
      idx = 32'(beat_q) * LANES + j;
      xl  = x_data[j*W +: W];
      th  = theta_q[idx[AW-1:0]];
      if (x_fire) begin
        prod_d[j] = '0;
        if (idx == 0) begin
          prod_d[j] = {{W{theta_q[0][W-1]}}, theta_q[0]};
        end else if (idx < N_FEAT && !ZERO_MASK[idx[AW-1:0]]) begin
          prod_d[j] = {{W{xl[W-1]}}, xl} * {{W{th[W-1]}}, th};
        end
      end
    end
  end

  // Stage 2: fold registered lane products into the accumulator.
  always_comb begin
    lane_sum = '0;
    for (int unsigned j = 0; j < LANES; j++) begin
      lane_sum = lane_sum + {{(AccW-PW){prod_q[j][PW-1]}}, prod_q[j]};
    end
    acc_d = acc_q;
    if (h_fire) acc_d = '0;
    else if (pv_q) acc_d = acc_q + lane_sum;
  end

  // Final value: wrap to W bits, or clamp to the signed W-bit range.
  always_comb begin
    logic [W-1:0] sat_res;
    if (acc_q > MaxV)      sat_res = MaxV[W-1:0];
    else if (acc_q < MinV) sat_res = MinV[W-1:0];
    else                   sat_res = acc_q[W-1:0];
    result = SAT ? sat_res : acc_q[W-1:0];
  end

  // Control FSM next state; outputs are registered from the next state.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    h_data_d = h_data_q;
    case (state_q)
      StIdle: begin
        if (x_fire) begin
          if (BEATS == 1) begin
            state_d = StFlush1;
          end else begin
            state_d = StRun;
            beat_d  = CW'(1);
          end
        end
      end
      StRun: begin
        if (x_fire) begin
          if (beat_q == LastBeat) begin
            state_d = StFlush1;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StFlush1: state_d = StFlush2;
      StFlush2: begin
        // Last lane sum entered acc at the previous edge.
        state_d  = StDone;
        h_data_d = result;
      end
      StDone: begin
        if (h_fire) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    x_ready_d = (state_d == StIdle) || (state_d == StRun);
    h_valid_d = (state_d == StDone);
    busy_d    = (state_d != StIdle);
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      beat_q      <= '0;
      x_ready_q   <= 1'b1;
      h_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      h_data_q    <= '0;
      theta_err_q <= 1'b0;
      theta_q     <= '{default: '0};
      prod_q      <= '{default: '0};
      pv_q        <= 1'b0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      x_ready_q   <= x_ready_d;
      h_valid_q   <= h_valid_d;
      busy_q      <= busy_d;
      h_data_q    <= h_data_d;
      theta_err_q <= theta_err_d;
      theta_q     <= theta_d;
      prod_q      <= prod_d;
      pv_q        <= pv_d;
      acc_q       <= acc_d;
    end
  end

endmodule

// File: tb/tb_innerproduct_stream.sv
// Directed bench for innerproduct_stream: a modulo instance and a saturating
// instance share all inputs; expected values are hand-computed constants.
module tb_innerproduct_stream;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         theta_we = 1'b0;
  logic [5:0]   theta_addr = '0;
  logic [31:0]  theta_wdata = '0;
  logic         x_valid = 1'b0;
  logic [127:0] x_data = '0;
  logic         h_ready = 1'b1;

  logic        theta_err, x_ready, h_valid, busy;
  logic [31:0] h_data;
  logic        s_theta_err, s_x_ready, s_h_valid, s_busy;
  logic [31:0] s_h_data;

  int total = 0;
  int bad   = 0;
  int x_hs  = 0;
  int h_hs  = 0;

  logic [31:0] x_vec [0:43];

  always #5 clk = ~clk;

  innerproduct_stream #(.SAT(1'b0)) u_dut (
    .clk(clk), .rst(rst), .theta_we(theta_we), .theta_addr(theta_addr),
    .theta_wdata(theta_wdata), .theta_err(theta_err), .x_valid(x_valid),
    .x_ready(x_ready), .x_data(x_data), .h_valid(h_valid), .h_ready(h_ready),
    .h_data(h_data), .busy(busy)
  );

  innerproduct_stream #(.SAT(1'b1)) u_dut_sat (
    .clk(clk), .rst(rst), .theta_we(theta_we), .theta_addr(theta_addr),
    .theta_wdata(theta_wdata), .theta_err(s_theta_err), .x_valid(x_valid),
    .x_ready(s_x_ready), .x_data(x_data), .h_valid(s_h_valid), .h_ready(h_ready),
    .h_data(s_h_data), .busy(s_busy)
  );

  // Handshake counters, sampled mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (!rst && x_valid && x_ready) x_hs++;
    if (!rst && h_valid && h_ready) h_hs++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic write_theta(input int a, input logic [31:0] d);
    theta_we    = 1'b1;
    theta_addr  = 6'(a);
    theta_wdata = d;
    @(posedge clk); #1;
    theta_we = 1'b0;
  endtask

  task automatic load_theta1();
    for (int k = 0; k < 41; k++) write_theta(k, (k == 0) ? 32'd5 : 32'(k));
  endtask

  // x[0] and x[1] carry junk that must be ignored; padding lanes too.
  task automatic set_vec1();
    for (int k = 0; k < 44; k++)
      x_vec[k] = (k == 0) ? 32'd9 : (k == 1) ? 32'd3 : (k < 41) ? 32'd1 : 32'd7;
  endtask

  task automatic drive_beat(input int b);
    for (int j = 0; j < 4; j++) x_data[j*32 +: 32] = x_vec[b*4 + j];
  endtask

  task automatic send_beats(input int first, input int last, input bit gaps);
    for (int b = first; b <= last; b++) begin
      int n;
      n = 0;
      x_valid = 1'b1;
      drive_beat(b);
      while (!x_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n == 50) begin
        check("send_timeout", 32'd0, 32'd1);
        x_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      x_valid = 1'b0;
      if (gaps && b != last) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_h(input string tag);
    int n;
    n = 0;
    while (!h_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(h_valid), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int hs0, hh0;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0, hh0;
    for (int k = 0; k < 44; k++) x_vec[k] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_x_ready", 32'(x_ready), 32'd1);
    check("rst_h_valid", 32'(h_valid), 32'd0);
    check("rst_h_data", h_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_theta_err", 32'(theta_err), 32'd0);
    @(posedge clk); #1;

    // Test 1: basic vector, exact two-cycle latency
    load_theta1();
    set_vec1();
    h_ready = 1'b1;
    send_beats(0, 10, 1'b0);
    @(negedge clk);
    check("t1_lat_e0", 32'(h_valid), 32'd0);
    @(negedge clk);
    check("t1_lat_e1", 32'(h_valid), 32'd0);
    @(negedge clk);
    check("t1_lat_e2", 32'(h_valid), 32'd1);
    check("t1_h_data", h_data, 32'd824);
    check("t1_sat_h_data", s_h_data, 32'd824);
    check("t1_x_ready_done", 32'(x_ready), 32'd0);
    check("t1_busy_done", 32'(busy), 32'd1);
    @(negedge clk);
    check("t1_h_valid_after", 32'(h_valid), 32'd0);
    check("t1_x_ready_after", 32'(x_ready), 32'd1);
    check("t1_busy_after", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Test 2: backpressure holds result
    h_ready = 1'b0;
    send_beats(0, 10, 1'b0);
    wait_h("t2_wait");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t2_hold_valid", 32'(h_valid), 32'd1);
      check("t2_hold_data", h_data, 32'd824);
      check("t2_hold_x_ready", 32'(x_ready), 32'd0);
    end
    h_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("t2_x_ready_after", 32'(x_ready), 32'd1);
    check("t2_h_valid_after", 32'(h_valid), 32'd0);
    @(posedge clk); #1;

    // Test 3: modulo vs saturating arithmetic
    do_reset();
    for (int k = 0; k < 44; k++) x_vec[k] = '0;
    x_vec[2] = 32'h0001_0000;
    write_theta(2, 32'h0001_0000);
    send_beats(0, 10, 1'b0);
    wait_h("t3a_wait");
    check("t3a_mod", h_data, 32'h0000_0000);
    check("t3a_sat", s_h_data, 32'h7FFF_FFFF);
    @(posedge clk); #1;
    x_vec[2] = 32'd5;
    write_theta(2, 32'hFFFF_FFFF);
    send_beats(0, 10, 1'b0);
    wait_h("t3b_wait");
    check("t3b_mod", h_data, 32'hFFFF_FFFB);
    check("t3b_sat", s_h_data, 32'hFFFF_FFFB);
    @(posedge clk); #1;

    // Test 4: theta write while busy is dropped, out-of-range write too
    load_theta1();
    set_vec1();
    send_beats(0, 2, 1'b0);
    write_theta(3, 32'd100);
    @(negedge clk);
    check("t4_err_pulse", 32'(theta_err), 32'd1);
    @(negedge clk);
    check("t4_err_clear", 32'(theta_err), 32'd0);
    send_beats(3, 10, 1'b0);
    wait_h("t4_wait");
    check("t4_h_data", h_data, 32'd824);
    @(posedge clk); #1;
    write_theta(41, 32'd55);
    @(negedge clk);
    check("t4_oob_err", 32'(theta_err), 32'd1);
    @(negedge clk);
    check("t4_oob_clear", 32'(theta_err), 32'd0);
    @(posedge clk); #1;

    // Test 5: reset mid-vector
    send_beats(0, 4, 1'b0);
    rst = 1'b1;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_x_ready", 32'(x_ready), 32'd1);
    check("t5_h_valid", 32'(h_valid), 32'd0);
    check("t5_h_data", h_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    load_theta1();
    send_beats(0, 10, 1'b0);
    wait_h("t5_wait");
    check("t5_h_data_after", h_data, 32'd824);
    check("t5_sat_after", s_h_data, 32'd824);
    @(posedge clk); #1;

    // Test 6: x_valid toggling every cycle
    hs0 = x_hs;
    hh0 = h_hs;
    send_beats(0, 10, 1'b1);
    wait_h("t6_wait");
    check("t6_h_data", h_data, 32'd824);
    repeat (10) @(negedge clk);
    check("t6_x_hs", 32'(x_hs - hs0), 32'd11);
    check("t6_h_hs", 32'(h_hs - hh0), 32'd1);
    @(posedge clk); #1;

    // Test 7: write and first beat in the same idle cycle
    theta_we    = 1'b1;
    theta_addr  = 6'd0;
    theta_wdata = 32'd1000;
    x_valid     = 1'b1;
    drive_beat(0);
    @(posedge clk); #1;
    theta_we = 1'b0;
    x_valid  = 1'b0;
    @(negedge clk);
    check("t7_no_err", 32'(theta_err), 32'd0);
    send_beats(1, 10, 1'b0);
    wait_h("t7a_wait");
    check("t7_old_theta", h_data, 32'd824);
    @(posedge clk); #1;
    send_beats(0, 10, 1'b0);
    wait_h("t7b_wait");
    check("t7_new_theta", h_data, 32'd1819);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
